// File: rtl/fb_pkg.sv
// Shared constants and types for the double-buffered frame store.
package fb_pkg;

    localparam int FB_WIDTH_DEF  = 400;
    localparam int FB_HEIGHT_DEF = 240;
    localparam int FB_ADDR_W_DEF = $clog2(FB_WIDTH_DEF * FB_HEIGHT_DEF);
    localparam int PIX_W         = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } swap_state_e;

endpackage

// File: rtl/fb_bank.sv
// One pixel bank: single write port, registered read port, contents not reset.
module fb_bank #(
    parameter int DEPTH = 96000,
    parameter int AW    = 17,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    // Read and write on the same edge to the same word yields the old word.
    always_ff @(posedge clk) begin
        if (re_i) rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_buffer.sv
// Pixel store between GPU writes and scanout; bank swap deferred to vblank.
// Define FRAME_BUFFER_DOUBLE_EN for two banks; otherwise a single shared bank.
module frame_buffer
    import fb_pkg::*;
#(
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [$clog2(FB_WIDTH):0]      fb_x,
    input  logic [$clog2(FB_HEIGHT):0]     fb_y,
    input  logic [PIX_W-1:0]               fb_color,
    input  logic                           fb_write,
    input  logic [$clog2(FB_WIDTH):0]      scan_x,
    input  logic [$clog2(FB_HEIGHT):0]     scan_y,
    input  logic                           scan_read,
    input  logic                           scan_vblank,
    output logic [PIX_W-1:0]               scan_color,
    output logic                           scan_valid,
    input  logic                           swap_req,
    output logic                           swap_pending,
    output logic                           swap_done,
    output logic                           front_sel
);

    localparam int XW    = $clog2(FB_WIDTH) + 1;
    localparam int YW    = $clog2(FB_HEIGHT) + 1;
    localparam int PIX   = FB_WIDTH * FB_HEIGHT;
    localparam int AW    = $clog2(PIX);
    localparam int FW    = XW + YW + 1;

    // Full-width linear addresses; truncation happens only after the range check.
    logic [FW-1:0] wr_lin, rd_lin;
    logic          wr_ok, rd_oob;

    assign wr_lin = FW'(fb_y) * FW'(FB_WIDTH) + FW'(fb_x);
    assign rd_lin = FW'(scan_y) * FW'(FB_WIDTH) + FW'(scan_x);
    assign wr_ok  = fb_write && (fb_x < XW'(FB_WIDTH)) && (fb_y < YW'(FB_HEIGHT));
    assign rd_oob = (scan_x >= XW'(FB_WIDTH)) || (scan_y >= YW'(FB_HEIGHT));

    logic              wr_vld_q;
    logic [AW-1:0]     wr_addr_q;
    logic [PIX_W-1:0]  wr_data_q;
    logic [1:0]        rd_vld_q;
    logic [1:0]        rd_oob_q;
    logic [AW-1:0]     rd_addr_q;
    logic              commit;
    logic [PIX_W-1:0]  bank_rdata;

    swap_state_e state_q, state_d;
    logic        front_q, front_d;
    logic        done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_vld_q <= 1'b0;
            rd_vld_q <= 2'b00;
        end else begin
            wr_vld_q <= wr_ok;
            rd_vld_q <= {rd_vld_q[0], scan_read};
        end
    end

    always_ff @(posedge clk) begin
        wr_addr_q <= AW'(wr_lin);
        wr_data_q <= fb_color;
        rd_addr_q <= rd_oob ? '0 : AW'(rd_lin);
        rd_oob_q  <= {rd_oob_q[0], rd_oob};
    end

    // A write still in stage 0 when reset arrives must not reach the RAM.
    assign commit = wr_vld_q && !reset;

`ifdef FRAME_BUFFER_DOUBLE_EN
    logic             wr_bank_q;
    logic [1:0]       rd_bank_q;
    logic [PIX_W-1:0] rdata0, rdata1;

    // Bank is fixed at acceptance so a swap mid-flight cannot redirect it.
    always_ff @(posedge clk) begin
        wr_bank_q <= ~front_q;
        rd_bank_q <= {rd_bank_q[0], front_q};
    end

    fb_bank #(.DEPTH(PIX), .AW(AW), .DW(PIX_W)) u_bank0 (
        .clk     (clk),
        .we_i    (commit && !wr_bank_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .re_i    (rd_vld_q[0]),
        .raddr_i (rd_addr_q),
        .rdata_o (rdata0)
    );

    fb_bank #(.DEPTH(PIX), .AW(AW), .DW(PIX_W)) u_bank1 (
        .clk     (clk),
        .we_i    (commit && wr_bank_q),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .re_i    (rd_vld_q[0]),
        .raddr_i (rd_addr_q),
        .rdata_o (rdata1)
    );

    assign bank_rdata = rd_bank_q[1] ? rdata1 : rdata0;
`else
    fb_bank #(.DEPTH(PIX), .AW(AW), .DW(PIX_W)) u_bank0 (
        .clk     (clk),
        .we_i    (commit),
        .waddr_i (wr_addr_q),
        .wdata_i (wr_data_q),
        .re_i    (rd_vld_q[0]),
        .raddr_i (rd_addr_q),
        .rdata_o (bank_rdata)
    );
`endif

    assign scan_valid = rd_vld_q[1];
    assign scan_color = (rd_vld_q[1] && !rd_oob_q[1]) ? bank_rdata : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            front_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            done_q  <= done_d;
        end
    end

    // Vblank is only honoured from PENDING, so a request arriving during vblank waits a cycle.
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (swap_req) state_d = PENDING;
            end
            PENDING: begin
                if (scan_vblank) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
`ifdef FRAME_BUFFER_DOUBLE_EN
                    front_d = ~front_q;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign swap_pending = (state_q == PENDING);
    assign swap_done    = done_q;
    assign front_sel    = front_q;

endmodule

// File: doc/frame_buffer.md
# frame_buffer

Double-buffered pixel store between the GPU pixel-write port and the display scanout. The GPU writes 16-bit pixels by (x, y) into the back buffer while scanout reads the front buffer. A swap request exchanges the two banks at the next vertical blank, so scanout never shows a partially drawn frame.

## Interface
- FB_WIDTH, 400, pixels per line
- FB_HEIGHT, 240, lines per frame
- clk  in  1  single clock, all logic on posedge
- reset  in  1  synchronous, active-high
- fb_x  in  $clog2(FB_WIDTH)+1  GPU write x
- fb_y  in  $clog2(FB_HEIGHT)+1  GPU write y
- fb_color  in  16  GPU write pixel (bit 0 transparency already resolved upstream; stored as-is)
- fb_write  in  1  write strobe, one pixel per cycle
- scan_x  in  $clog2(FB_WIDTH)+1  scanout read x
- scan_y  in  $clog2(FB_HEIGHT)+1  scanout read y
- scan_read  in  1  read strobe
- scan_vblank  in  1  high during display vertical blank
- scan_color  out  16  front-buffer pixel
- scan_valid  out  1  scan_color valid this cycle
- swap_req  in  1  request bank exchange (level, sampled when IDLE)
- swap_pending  out  1  swap requested, waiting for vblank
- swap_done  out  1  one-cycle pulse when exchange takes effect
- front_sel  out  1  bank currently shown (0 or 1)

## Operation
- Two banks of FB_WIDTH*FB_HEIGHT x 16 bits. Back bank = !front_sel.
- Linear address = y*FB_WIDTH + x, width $clog2(FB_WIDTH*FB_HEIGHT). Computed at full width, with no truncation before the range check.
- Write path: a write with fb_x >= FB_WIDTH or fb_y >= FB_HEIGHT is dropped. No other state changes.
- Read path: an out-of-range scan read returns scan_color = 0 with scan_valid = 1.
- Swap FSM states:
  - IDLE: if swap_req, go to PENDING and set swap_pending.
  - PENDING: if scan_vblank, toggle front_sel, pulse swap_done, clear swap_pending, and return to IDLE.
  - swap_req is ignored while in PENDING.
- swap_req and scan_vblank in the same cycle while IDLE: enter PENDING only. The toggle occurs the next cycle if vblank is still high.
- Bank choice for each write and read is latched in pipeline stage 0. An in-flight operation completes to the bank chosen at acceptance, even if front_sel toggles.
- Memory contents are not reset.

## Timing
- Reset values: front_sel=0, swap_pending=0, swap_done=0, scan_valid=0, scan_color=0, FSM=IDLE. Pipeline valid bits are cleared, so in-flight writes are discarded.
- Write latency: strobe in cycle N (address/bank registered) commits in cycle N+1. A read of the same pixel issued in cycle N+2 or later sees the new value.
- Read latency: scan_read in cycle N gives scan_valid/scan_color in cycle N+2. The path is fully pipelined, one read per cycle.
- Write and read in the same cycle are always accepted; they target different banks in double-buffered mode.
- front_sel changes on the edge after the PENDING cycle that sees scan_vblank. swap_done is high for exactly that following cycle.

## Configuration
- FRAME_BUFFER_DOUBLE_EN defined: behaviour as above, two banks.
- Not defined: one bank only.
  - Writes and reads share that bank. A same-address write and read in the same cycle returns the old data.
  - swap_req still runs the FSM and pulses swap_done at vblank, so the controller interface is unchanged.
  - front_sel is held at 0.

## Structure
- Package fb_pkg: FB_WIDTH/FB_HEIGHT defaults, address-width constant, swap state enum (IDLE, PENDING).
- Sub-module fb_bank: simple dual-port RAM with one write port and one registered read port, instantiated once or twice depending on the macro.

## Test plan
- Reset, then write (10,20)=0xABCD in bank 1, swap_req, vblank pulse, read (10,20) -> scan_color 0xABCD at N+2, front_sel=1, swap_done single pulse.
- Write (400,0) and (0,240), then swap and read (0,0) -> stored data is unchanged; out-of-range read (400,5) -> 0x0000 with scan_valid=1.
- swap_req with scan_vblank held low for 100 cycles -> swap_pending=1 throughout, front_sel stays 0. Vblank high -> front_sel=1 on the next edge.
- Write (5,5)=0x1111 in the cycle front_sel toggles -> the value lands in the old back bank (now front) and reads back 0x1111 after the swap.
- Back-to-back reads over a full 400-pixel line during continuous writes -> 400 consecutive scan_valid cycles with correct data and no stalls.
- Assert reset in the cycle after a write strobe -> the write is dropped and all outputs take their reset values the next cycle. Repeat with FRAME_BUFFER_DOUBLE_EN undefined: same-cycle same-address read returns the old value.
